// File: rtl/round_ctrl_if.sv
// Bundle between the match sequencer and its surroundings: debounced
// button pulses and ball position in, game status and scores out.
interface round_ctrl_if;
  logic        btn_start;
  logic        btn_mode;
  logic [11:0] ball_pos_x;
  logic [11:0] ball_pos_y;
  logic [1:0]  game_state;
  logic        game_mode;
  logic        freeze;
  logic [3:0]  score_player;
  logic [3:0]  score_npc;
  logic        serve_npc;
  logic        point_pulse;
  logic        winner_npc;

  // Side that drives buttons/ball and observes the match status
  modport master (
    output btn_start, btn_mode, ball_pos_x, ball_pos_y,
    input  game_state, game_mode, freeze, score_player, score_npc,
           serve_npc, point_pulse, winner_npc
  );

  // The sequencer itself
  modport slave (
    input  btn_start, btn_mode, ball_pos_x, ball_pos_y,
    output game_state, game_mode, freeze, score_player, score_npc,
           serve_npc, point_pulse, winner_npc
  );
endinterface

// File: rtl/round_ctrl.sv
// Volleyball match sequencer: phase FSM (IDLE/SERVE/PLAY/POINT/OVER),
// landing detection, scoring, serve side and ball-physics freeze.
// Every output is a register updated on the same edge as the state.
module round_ctrl #(
  parameter int SERVE_CYCLES = 50_000_000,
  parameter int POINT_CYCLES = 100_000_000,
  parameter int WIN_SCORE    = 15,
  parameter int GROUND_Y     = 220,
  parameter int BALL_H       = 40,
  parameter int NET_X        = 160
) (
  input  logic         clk,
  input  logic         reset_n,
  round_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } state_t;

  localparam logic [26:0] SERVE_LAST = 27'(SERVE_CYCLES - 1);
  localparam logic [26:0] POINT_LAST = 27'(POINT_CYCLES - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [12:0] GROUND     = 13'(GROUND_Y);
  localparam logic [12:0] BALL       = 13'(BALL_H);
  localparam logic [11:0] NET        = 12'(NET_X);

  state_t      state_reg;
  logic [26:0] timer_reg;
  logic [1:0]  game_state_reg;
  logic        mode_reg;
  logic        freeze_reg;
  logic [3:0]  score_player_reg;
  logic [3:0]  score_npc_reg;
  logic        serve_npc_reg;
  logic        point_reg;
  logic        winner_reg;

  // Ball bottom edge computed one bit wider so a large y never wraps below ground
  logic [12:0] ball_bottom;
  logic        landing;
  logic        on_npc_half;

  assign ball_bottom = {1'b0, bus.ball_pos_y} + BALL;
  assign landing     = (ball_bottom >= GROUND);
  assign on_npc_half = (bus.ball_pos_x < NET);

  // Match sequencing, phase timing and scoring
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      game_state_reg   <= 2'd0;
      mode_reg         <= 1'b0;
      freeze_reg       <= 1'b1;
      score_player_reg <= '0;
      score_npc_reg    <= '0;
      serve_npc_reg    <= 1'b0;
      point_reg        <= 1'b0;
      winner_reg       <= 1'b0;
    end else begin
      point_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Start has priority; mode only toggles when no start arrives
          if (bus.btn_start) begin
            score_player_reg <= '0;
            score_npc_reg    <= '0;
            serve_npc_reg    <= 1'b0;
            winner_reg       <= 1'b0;
            state_reg        <= ST_SERVE;
            game_state_reg   <= 2'd1;
            freeze_reg       <= 1'b1;
            timer_reg        <= '0;
          end else if (bus.btn_mode) begin
            mode_reg <= ~mode_reg;
          end
        end
        ST_SERVE: begin
          if (timer_reg == SERVE_LAST) begin
            state_reg      <= ST_PLAY;
            game_state_reg <= 2'd2;
            freeze_reg     <= 1'b0;
            timer_reg      <= '0;
          end else begin
            timer_reg <= timer_reg + 27'd1;
          end
        end
        ST_PLAY: begin
          // The half the ball lands on loses the point
          if (landing) begin
            if (on_npc_half) begin
              score_player_reg <= score_player_reg + 4'd1;
              serve_npc_reg    <= 1'b0;
            end else begin
              score_npc_reg <= score_npc_reg + 4'd1;
              serve_npc_reg <= 1'b1;
            end
            point_reg  <= 1'b1;
            state_reg  <= ST_POINT;
            freeze_reg <= 1'b1;
            timer_reg  <= '0;
          end
        end
        ST_POINT: begin
          if (timer_reg == POINT_LAST) begin
            timer_reg <= '0;
            if ((score_player_reg == WIN) || (score_npc_reg == WIN)) begin
              state_reg      <= ST_OVER;
              game_state_reg <= 2'd3;
              winner_reg     <= (score_npc_reg == WIN);
            end else begin
              state_reg      <= ST_SERVE;
              game_state_reg <= 2'd1;
            end
          end else begin
            timer_reg <= timer_reg + 27'd1;
          end
        end
        ST_OVER: begin
          // Scores stay on display until the next start clears them
          if (bus.btn_start) begin
            state_reg      <= ST_IDLE;
            game_state_reg <= 2'd0;
            timer_reg      <= '0;
          end
        end
        default: begin
          state_reg      <= ST_IDLE;
          game_state_reg <= 2'd0;
          freeze_reg     <= 1'b1;
          timer_reg      <= '0;
        end
      endcase
    end
  end

  assign bus.game_state   = game_state_reg;
  assign bus.game_mode    = mode_reg;
  assign bus.freeze       = freeze_reg;
  assign bus.score_player = score_player_reg;
  assign bus.score_npc    = score_npc_reg;
  assign bus.serve_npc    = serve_npc_reg;
  assign bus.point_pulse  = point_reg;
  assign bus.winner_npc   = winner_reg;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus pushes expected phase changes,
// points and mode toggles; a negedge monitor pops and compares them.
module tb_round_ctrl;
  localparam int SERVE_N = 4;
  localparam int POINT_N = 6;
  localparam int WIN_N   = 3;
  localparam int NET     = 160;

  localparam int PH_IDLE  = 0;
  localparam int PH_SERVE = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_POINT = 3;
  localparam int PH_OVER  = 4;

  typedef struct { int ph; int len; int sp; int sn; int srv; int win; } phase_t;
  typedef struct { int sp; int sn; int srv; } point_t;

  logic clk = 1'b0;
  logic reset_n;
  round_ctrl_if bus ();

  round_ctrl #(
    .SERVE_CYCLES(SERVE_N), .POINT_CYCLES(POINT_N), .WIN_SCORE(WIN_N),
    .GROUND_Y(220), .BALL_H(40), .NET_X(NET)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  phase_t ph_q[$];
  point_t pt_q[$];
  int     mode_q[$];

  // Reference match state
  int m_sp = 0, m_sn = 0, m_srv = 0, m_mode = 0;

  // Monitor view
  bit mon_en = 0;
  int cur_ph = PH_IDLE;
  int run_len = 0;
  logic cur_mode = 1'b0;
  bit rst_pend = 0;

  function automatic int phase_of(logic [1:0] gs, logic fz);
    case ({gs, fz})
      3'b001:  return PH_IDLE;
      3'b011:  return PH_SERVE;
      3'b100:  return PH_PLAY;
      3'b101:  return PH_POINT;
      3'b111:  return PH_OVER;
      default: return 7;
    endcase
  endfunction

  // Monitor: compares observed events against the queued expectations
  always @(negedge clk) begin : monitor
    int ph;
    phase_t e;
    point_t p;
    int m;
    if (mon_en) begin
      ph = phase_of(bus.game_state, bus.freeze);
      if (ph != cur_ph) begin
        checks++;
        if (ph_q.size() == 0) begin
          errors++;
          $display("FAIL phase_unexpected got=%0d previous=%0d", ph, cur_ph);
        end else begin
          e = ph_q.pop_front();
          if (ph != e.ph || (e.len >= 0 && run_len != e.len) ||
              (e.sp >= 0 && int'(bus.score_player) != e.sp) ||
              (e.sn >= 0 && int'(bus.score_npc) != e.sn) ||
              (e.srv >= 0 && int'(bus.serve_npc) != e.srv) ||
              (e.win >= 0 && int'(bus.winner_npc) != e.win)) begin
            errors++;
            $display("FAIL phase got ph=%0d prevlen=%0d sp=%0d sn=%0d srv=%0d win=%0d required ph=%0d prevlen=%0d sp=%0d sn=%0d srv=%0d win=%0d",
                     ph, run_len, bus.score_player, bus.score_npc, bus.serve_npc, bus.winner_npc,
                     e.ph, e.len, e.sp, e.sn, e.srv, e.win);
          end else begin
            $display("phase ok ph=%0d prevlen=%0d sp=%0d sn=%0d", ph, run_len, bus.score_player, bus.score_npc);
          end
        end
        cur_ph = ph;
        run_len = 1;
      end else begin
        run_len++;
      end

      if (bus.point_pulse === 1'b1) begin
        checks++;
        if (pt_q.size() == 0) begin
          errors++;
          $display("FAIL point_unexpected sp=%0d sn=%0d", bus.score_player, bus.score_npc);
        end else begin
          p = pt_q.pop_front();
          if (int'(bus.score_player) != p.sp || int'(bus.score_npc) != p.sn ||
              int'(bus.serve_npc) != p.srv || ph != PH_POINT) begin
            errors++;
            $display("FAIL point got sp=%0d sn=%0d srv=%0d ph=%0d required sp=%0d sn=%0d srv=%0d ph=%0d",
                     bus.score_player, bus.score_npc, bus.serve_npc, ph, p.sp, p.sn, p.srv, PH_POINT);
          end else begin
            $display("point ok sp=%0d sn=%0d srv=%0d", p.sp, p.sn, p.srv);
          end
        end
      end

      if (bus.game_mode !== cur_mode) begin
        checks++;
        if (mode_q.size() == 0) begin
          errors++;
          $display("FAIL mode_unexpected got=%0b", bus.game_mode);
        end else begin
          m = mode_q.pop_front();
          if (int'(bus.game_mode) != m) begin
            errors++;
            $display("FAIL mode got=%0b required=%0d", bus.game_mode, m);
          end else begin
            $display("mode ok %0d", m);
          end
        end
        cur_mode = bus.game_mode;
      end

      if (rst_pend) begin
        checks++;
        if (bus.game_state !== 2'd0 || bus.game_mode !== 1'b0 || bus.freeze !== 1'b1 ||
            bus.score_player !== 4'd0 || bus.score_npc !== 4'd0 || bus.serve_npc !== 1'b0 ||
            bus.point_pulse !== 1'b0 || bus.winner_npc !== 1'b0) begin
          errors++;
          $display("FAIL reset_values got gs=%0d mode=%0b frz=%0b sp=%0d sn=%0d srv=%0b pp=%0b win=%0b required 0 0 1 0 0 0 0 0",
                   bus.game_state, bus.game_mode, bus.freeze, bus.score_player, bus.score_npc,
                   bus.serve_npc, bus.point_pulse, bus.winner_npc);
        end else begin
          $display("reset ok");
        end
      end
      rst_pend = (reset_n == 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit m);
    bus.btn_start = s;
    bus.btn_mode  = m;
    tick();
    bus.btn_start = 1'b0;
    bus.btn_mode  = 1'b0;
  endtask

  task automatic wait_phase(input int target, input string what);
    int n;
    n = 0;
    while (cur_ph != target && n < 60) begin
      tick();
      n++;
    end
    if (cur_ph != target) begin
      checks++;
      errors++;
      $display("FAIL wait_%s phase=%0d required=%0d", what, cur_ph, target);
    end
  endtask

  function automatic void push_phase(int ph, int len, int sp, int sn, int srv, int win);
    ph_q.push_back('{ph, len, sp, sn, srv, win});
  endfunction

  function automatic int pick_x(int bias);
    if (bias == 1) return $urandom_range(NET, 4095);
    if (bias == 2) return $urandom_range(0, NET - 1);
    case ($urandom_range(0, 3))
      0:       return NET - 1;
      1:       return NET;
      2:       return $urandom_range(0, NET - 1);
      default: return $urandom_range(NET, 4095);
    endcase
  endfunction

  function automatic int pick_land_y();
    case ($urandom_range(0, 3))
      0:       return 180;
      1:       return $urandom_range(181, 300);
      2:       return 4095;
      default: return $urandom_range(180, 4095);
    endcase
  endfunction

  // Put the ball on the ground and record what that rally should produce
  task automatic land(input int x, input int y, input bit with_exit);
    bus.ball_pos_x = 12'(x);
    bus.ball_pos_y = 12'(y);
    if (x < NET) begin
      m_sp++;
      m_srv = 0;
    end else begin
      m_sn++;
      m_srv = 1;
    end
    pt_q.push_back('{m_sp, m_sn, m_srv});
    push_phase(PH_POINT, -1, m_sp, m_sn, m_srv, -1);
    if (with_exit) begin
      if (m_sp == WIN_N || m_sn == WIN_N)
        push_phase(PH_OVER, POINT_N, m_sp, m_sn, m_srv, (m_sn == WIN_N) ? 1 : 0);
      else
        push_phase(PH_SERVE, POINT_N, m_sp, m_sn, m_srv, -1);
    end
  endtask

  task automatic play_match(input int bias, input bit scripted);
    bit relanded;
    bit over;
    int rally;
    int r;
    int x;
    int y;
    relanded = 0;
    over = 0;
    rally = 0;
    while (!over && rally < 12) begin
      if (!relanded) begin
        wait_phase(PH_PLAY, "play");
        // One pixel above ground at the net: must not score
        bus.ball_pos_x = 12'(NET);
        bus.ball_pos_y = 12'(179);
        repeat ($urandom_range(1, 3)) begin
          r = $urandom_range(0, 3);
          bus.btn_start = (r == 1);
          bus.btn_mode  = (r == 2);
          tick();
          bus.btn_start = 1'b0;
          bus.btn_mode  = 1'b0;
        end
        if (scripted && rally == 0) begin
          x = 100; y = 190;
        end else if (scripted && rally == 1) begin
          x = NET; y = 180;
        end else begin
          x = pick_x(bias); y = pick_land_y();
        end
        land(x, y, 1'b1);
      end
      rally++;
      over = (m_sp == WIN_N || m_sn == WIN_N);
      // Ball stays on the ground through POINT; only one point may result
      wait_phase(PH_POINT, "point");
      if (over) begin
        wait_phase(PH_OVER, "over");
      end else begin
        wait_phase(PH_SERVE, "serve");
        push_phase(PH_PLAY, SERVE_N, m_sp, m_sn, m_srv, -1);
        relanded = ($urandom_range(0, 3) == 0) && !(scripted && rally < 2);
        if (relanded)
          land(pick_x(bias), pick_land_y(), 1'b1);
        else
          bus.ball_pos_y = 12'($urandom_range(0, 179));
      end
    end
  endtask

  task automatic end_match();
    bus.ball_pos_y = 12'($urandom_range(0, 179));
    push_phase(PH_IDLE, -1, m_sp, m_sn, m_srv, -1);
    pulse(1'b1, 1'b0);
    wait_phase(PH_IDLE, "idle");
  endtask

  task automatic start_game(input bit simul);
    repeat ($urandom_range(0, 2)) begin
      m_mode ^= 1;
      mode_q.push_back(m_mode);
      pulse(1'b0, 1'b1);
      tick();
    end
    bus.ball_pos_y = 12'($urandom_range(0, 179));
    m_sp = 0; m_sn = 0; m_srv = 0;
    push_phase(PH_SERVE, -1, 0, 0, 0, -1);
    push_phase(PH_PLAY, SERVE_N, 0, 0, 0, -1);
    pulse(1'b1, simul);
  endtask

  task automatic reset_pulse();
    push_phase(PH_IDLE, -1, 0, 0, 0, 0);
    if (m_mode == 1) mode_q.push_back(0);
    m_mode = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_sp = 0; m_sn = 0; m_srv = 0;
    bus.ball_pos_y = 12'($urandom_range(0, 179));
    wait_phase(PH_IDLE, "idle_after_reset");
  endtask

  initial begin
    reset_n = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_mode = 1'b0;
    bus.ball_pos_x = 12'd0;
    bus.ball_pos_y = 12'd0;
    tick();
    mon_en = 1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Mode toggles twice, then simultaneous start+mode: start wins
    m_mode = 1; mode_q.push_back(1);
    pulse(1'b0, 1'b1);
    tick();
    m_mode = 0; mode_q.push_back(0);
    pulse(1'b0, 1'b1);
    tick();
    push_phase(PH_SERVE, -1, 0, 0, 0, -1);
    push_phase(PH_PLAY, SERVE_N, 0, 0, 0, -1);
    pulse(1'b1, 1'b1);

    play_match(0, 1'b1);
    end_match();
    start_game(1'b0);
    play_match(1, 1'b0);
    end_match();
    start_game(1'b1);
    play_match(2, 1'b0);
    end_match();

    // Reset in the middle of SERVE
    m_mode ^= 1; mode_q.push_back(m_mode);
    pulse(1'b0, 1'b1);
    tick();
    push_phase(PH_SERVE, -1, 0, 0, 0, -1);
    pulse(1'b1, 1'b0);
    wait_phase(PH_SERVE, "serve_pre_reset");
    tick();
    reset_pulse();

    // Full serve after reset, then reset in the middle of POINT
    start_game(1'b0);
    wait_phase(PH_PLAY, "play_pre_reset");
    land(pick_x(0), 190, 1'b0);
    wait_phase(PH_POINT, "point_pre_reset");
    tick();
    reset_pulse();

    start_game(1'b0);
    play_match(0, 1'b0);
    end_match();
    repeat (3) tick();

    checks++;
    if (ph_q.size() != 0) begin
      errors++;
      $display("FAIL phase_queue_left got=%0d required=0", ph_q.size());
    end
    checks++;
    if (pt_q.size() != 0) begin
      errors++;
      $display("FAIL point_queue_left got=%0d required=0", pt_q.size());
    end
    checks++;
    if (mode_q.size() != 0) begin
      errors++;
      $display("FAIL mode_queue_left got=%0d required=0", mode_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Match sequencer for the volleyball game. It owns the `game_state` and `game_mode` signals consumed by the NPC, player and ball blocks. It detects ball landings from the shared ball position, keeps both scores, picks the serving side, and freezes ball physics between rallies. It sits between the debounced button inputs and every game-object block, in the single system clock domain.

## Interface
- `SERVE_CYCLES`, default 50_000_000: length of the SERVE phase in clocks (≥2).
- `POINT_CYCLES`, default 100_000_000: length of the post-point freeze in clocks (≥2).
- `WIN_SCORE`, default 15: score that ends the match (1..15).
- `GROUND_Y`, default 220: ground line in buffer pixels.
- `BALL_H`, default 40: ball sprite height.
- `NET_X`, default 160: net x position; a ball with x < NET_X is on the NPC half.
- `clk`  in  1: system clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `btn_start`  in  1: single-cycle pulse from the debounce block.
- `btn_mode`  in  1: single-cycle pulse from the debounce block.
- `ball_pos_x`  in  12: ball top-left x.
- `ball_pos_y`  in  12: ball top-left y.
- `game_state`  out  2: 0 IDLE, 1 SERVE, 2 PLAY/POINT, 3 OVER.
- `game_mode`  out  1: 0 hard, 1 easy.
- `freeze`  out  1: 1 = ball physics held.
- `score_player`  out  4: player score.
- `score_npc`  out  4: NPC score.
- `serve_npc`  out  1: 1 = next serve is from the NPC side.
- `point_pulse`  out  1: one-cycle strobe when a point is scored.
- `winner_npc`  out  1: valid in OVER; 1 = NPC won.

## Operation
- Internal FSM states: IDLE, SERVE, PLAY, POINT, OVER.
- `game_state` encoding: IDLE→0, SERVE→1, PLAY→2, POINT→2, OVER→3. It is a registered output.
- `freeze` is 1 in every state except PLAY. It is registered and changes on the same edge as the state.
- IDLE:
  - `btn_mode` toggles `game_mode`.
  - `btn_start` clears both scores, clears `serve_npc`, and goes to SERVE.
  - If `btn_start` and `btn_mode` arrive on the same cycle, start wins and mode is not toggled.
- `game_mode` is frozen outside IDLE. `btn_mode` is ignored there.
- SERVE: lasts exactly SERVE_CYCLES clocks, then goes to PLAY.
- PLAY, landing rule: a landing is ball_pos_y + BALL_H ≥ GROUND_Y, evaluated in 13 bits with no wrap.
- PLAY, scoring on landing:
  - If ball_pos_x < NET_X, the player scores and `serve_npc` goes to 0.
  - Otherwise (including x == NET_X), the NPC scores and `serve_npc` goes to 1.
  - The FSM then goes to POINT.
- PLAY, on the landing edge: `point_pulse` = 1 for exactly that one cycle, and the score increments on that same edge.
- POINT:
  - Lasts exactly POINT_CYCLES clocks.
  - If either score == WIN_SCORE, go to OVER and set `winner_npc` = (score_npc == WIN_SCORE). Otherwise go to SERVE.
  - Landings are ignored during POINT.
- OVER: scores and `winner_npc` hold. `btn_start` goes to IDLE and leaves the scores displayed until the next start.
- Phase timer: a single 27-bit counter.
  - It clears on every state entry.
  - A state exits when counter == LEN−1.
  - It is idle (0) in IDLE, PLAY and OVER.
- Buttons in SERVE, PLAY and POINT are ignored.

## Timing
- Reset values: state IDLE, `game_state` 0, `game_mode` 0, `freeze` 1, both scores 0, `serve_npc` 0, `point_pulse` 0, `winner_npc` 0, timer 0.
- Button to state: a button pulse sampled at edge k gives the new state and outputs visible after edge k.
- SERVE entered at edge k ⇒ PLAY at edge k+SERVE_CYCLES.
- Landing: inputs sampled at edge k ⇒ state POINT and updated score/`serve_npc` after edge k (1-cycle latency). `point_pulse` is high during cycle k..k+1 only.
- POINT entered at edge k ⇒ SERVE or OVER at edge k+POINT_CYCLES.
- A ball still below the ground on re-entry to PLAY counts as a landing on the first PLAY cycle. The ball block repositions the ball during SERVE.
- Reset mid-operation (any state): all outputs return to their reset values on the next edge, and any pending timer is discarded.

## Test plan
Parameters for all tests: SERVE_CYCLES=4, POINT_CYCLES=6, WIN_SCORE=3.
1. Reset, then `btn_mode`, then `btn_mode` two cycles later, then `btn_start` in the same cycle as `btn_mode` → `game_mode` 1 then 0, and stays 0 on the simultaneous pulse. `game_state` = 1 the cycle after start, and 2 exactly 4 cycles later with `freeze` falling.
2. In PLAY, drive ball (x=100, y=190) → next cycle: `game_state` 2, `freeze` 1, `score_player` 1, `serve_npc` 0, single `point_pulse`. `game_state` 1 six cycles later.
3. Landing at x=160, y=180 → `score_npc` increments and `serve_npc` = 1. Repeat with y=179 → no point.
4. NPC scores three times → after the third POINT, `game_state` 3, `winner_npc` 1, scores 0/3 held. `btn_start` → IDLE with scores still 0/3. Next `btn_start` → scores 0/0.
5. Hold a landing position continuously through POINT → exactly one increment per rally. `btn_start`/`btn_mode` pulses in PLAY have no effect.
6. Assert `reset_n` = 0 for one cycle mid-SERVE and again mid-POINT → all outputs equal their reset values on the next cycle. After release, the next `btn_start` gives a full 4-cycle SERVE.
